// File: rtl/fifo_out_pkg.sv
// fifo_out_pkg: shared constants and state encoding for the output FIFO controller.
//   AW       address width of the 32-entry output FIFO (matches the 5-to-32 write decoder)
//   DEPTH    entry count, always 2**AW
//   CW       occupancy counter width (must hold 0..DEPTH inclusive)
//   state_e  record of the operation performed at the last clock edge
package fifo_out_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [2:0] {
    StInit    = 3'd0,
    StNoOp    = 3'd1,
    StWrite   = 3'd2,
    StRead    = 3'd3,
    StWrRd    = 3'd4,
    StWrError = 3'd5,
    StRdError = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_out_ptr.sv
// fifo_out_ptr: AW-bit wrapping pointer register, used for both head and tail.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low clear (pointer returns to 0)
//   inc      advance the pointer by one at the next edge; wraps DEPTH-1 -> 0
//   ptr      current pointer value
module fifo_out_ptr
  import fifo_out_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] PtrOne = 1;

  logic [AW-1:0] ptr_q;

  // Natural AW-bit overflow gives the 31 -> 0 wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + PtrOne;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_out_ctrl.sv
// fifo_out_ctrl: pointer/status controller for the 32-entry factorial output FIFO.
//   clk, reset_n        clock (rising edge) and asynchronous active-low reset
//   wr_en, rd_en        write request (datapath) and read request (consumer)
//   wr_addr, we         tail pointer and qualified write enable for the write decoder
//   rd_addr, re         head pointer for the read mux and qualified pop strobe
//   data_count          occupancy 0..32; full/empty derived from it
//   wr_ack/wr_err       registered result of the previous cycle's write request
//   rd_ack/rd_err       registered result of the previous cycle's read request
// Build option: define FIFO_OUT_SIMUL_RW_EN to allow a write and a read in the same
// cycle. Without it, simultaneous requests are both ignored and the requester serializes.
module fifo_out_ctrl
  import fifo_out_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic          we,
  output logic [AW-1:0] rd_addr,
  output logic          re,
  output logic [CW-1:0] data_count,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);

  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [CW-1:0] CountOne  = 1;

  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          rd_err_q, rd_err_d;
  logic          we_int, re_int;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

  // Request qualification from registered status only, so we/re are valid in the
  // same cycle as the request.
  always_comb begin
    we_int = 1'b0;
    re_int = 1'b0;
`ifdef FIFO_OUT_SIMUL_RW_EN
    // When full, a concurrent read frees the slot the write lands in.
    we_int = wr_en & (~full | rd_en);
    re_int = rd_en & ~empty;
`else
    we_int = wr_en & ~rd_en & ~full;
    re_int = rd_en & ~wr_en & ~empty;
`endif
  end

  // Gate with reset so an in-flight write is never seen by the decoder during reset.
  assign we = we_int & reset_n;
  assign re = re_int & reset_n;

  always_comb begin
    count_d = count_q;
    case ({we_int, re_int})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = StNoOp;
    rd_err_d = 1'b0;
    if (wr_en && rd_en) begin
`ifdef FIFO_OUT_SIMUL_RW_EN
      // Empty: only the write can proceed, the read side still reports an error.
      state_d  = empty ? StWrite : StWrRd;
      rd_err_d = empty;
`else
      state_d  = StNoOp;
`endif
    end else if (wr_en) begin
      state_d = full ? StWrError : StWrite;
    end else if (rd_en) begin
      state_d  = empty ? StRdError : StRead;
      rd_err_d = empty;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      state_q  <= StInit;
      rd_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      state_q  <= state_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Write/read acks and the write error fall straight out of the recorded operation.
  // rd_err needs its own bit: a simultaneous request on an empty FIFO records StWrite
  // yet must still flag the rejected read.
  assign wr_ack     = (state_q == StWrite) || (state_q == StWrRd);
  assign wr_err     = (state_q == StWrError);
  assign rd_ack     = (state_q == StRead) || (state_q == StWrRd);
  assign rd_err     = rd_err_q;
  assign data_count = count_q;

  fifo_out_ptr u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (we_int),
    .ptr     (wr_addr)
  );

  fifo_out_ptr u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (re_int),
    .ptr     (rd_addr)
  );

endmodule

// File: tb/tb_fifo_out_ctrl.sv
// tb_fifo_out_ctrl: directed self-checking bench for fifo_out_ctrl.
// Inputs change 1 ns after a rising edge; combinational outputs are sampled 1 ns after
// that, registered outputs 1 ns after the next rising edge.
// Expectations follow FIFO_OUT_SIMUL_RW_EN when it is defined for the build.
module tb_fifo_out_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en;
  logic [4:0] wr_addr, rd_addr;
  logic       we, re;
  logic [5:0] data_count;
  logic       full, empty, wr_ack, wr_err, rd_ack, rd_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_out_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_addr    (wr_addr),
    .we         (we),
    .rd_addr    (rd_addr),
    .re         (re),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  // Drive one cycle of requests, then return to idle just after the edge.
  task automatic step(input logic w, input logic r);
    wr_en = w;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    #1;
    n_cmp++;
    if (we !== 1'b0) begin
      n_fail++; $display("FAIL reset_we: got %b want 0", we);
    end
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0;
    n_cmp++;
    if ({empty, full, data_count, wr_addr, rd_addr} !== {1'b1, 1'b0, 6'd0, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_status: got e%b f%b c%0d wa%0d ra%0d want e1 f0 c0 wa0 ra0",
               empty, full, data_count, wr_addr, rd_addr);
    end
    n_cmp++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
    end
    reset_n = 1'b1;
    step(1'b0, 1'b0);
    n_cmp++;
    if ({wr_ack, wr_err, rd_ack, rd_err, data_count} !== {4'b0000, 6'd0}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got flags %b c%0d want 0000 c0",
               {wr_ack, wr_err, rd_ack, rd_err}, data_count);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1;
      #1;
      n_cmp++;
      if (we !== 1'b1 || wr_addr !== 5'(i)) begin
        n_fail++; $display("FAIL fill_qual[%0d]: got we%b wa%0d want we1 wa%0d", i, we, wr_addr, i);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (wr_ack !== 1'b1 || data_count !== 6'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_ack[%0d]: got ack%b c%0d want ack1 c%0d", i, wr_ack, data_count, i + 1);
      end
    end
    n_cmp++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got f%b e%b want f1 e0", full, empty);
    end
    wr_en = 1'b1;
    #1;
    n_cmp++;
    if (we !== 1'b0) begin
      n_fail++; $display("FAIL overflow_we: got %b want 0", we);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    n_cmp++;
    if ({wr_err, wr_ack, wr_addr, data_count} !== {1'b1, 1'b0, 5'd0, 6'd32}) begin
      n_fail++;
      $display("FAIL overflow_err: got err%b ack%b wa%0d c%0d want err1 ack0 wa0 c32",
               wr_err, wr_ack, wr_addr, data_count);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (wr_err !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle: got %b want 0", wr_err);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      #1;
      n_cmp++;
      if (re !== 1'b1 || rd_addr !== 5'(i)) begin
        n_fail++; $display("FAIL drain_qual[%0d]: got re%b ra%0d want re1 ra%0d", i, re, rd_addr, i);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (rd_ack !== 1'b1 || data_count !== 6'(31 - i)) begin
        n_fail++;
        $display("FAIL drain_ack[%0d]: got ack%b c%0d want ack1 c%0d", i, rd_ack, data_count, 31 - i);
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_addr !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty: got e%b f%b ra%0d want e1 f0 ra0", empty, full, rd_addr);
    end
    rd_en = 1'b1;
    #1;
    n_cmp++;
    if (re !== 1'b0) begin
      n_fail++; $display("FAIL underflow_re: got %b want 0", re);
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    n_cmp++;
    if ({rd_err, rd_ack, rd_addr, data_count} !== {1'b1, 1'b0, 5'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL underflow_err: got err%b ack%b ra%0d c%0d want err1 ack0 ra0 c0",
               rd_err, rd_ack, rd_addr, data_count);
    end
  endtask

  // Pointers start at 0: 20 writes/20 reads put both at 20, then fill 20 (tail wraps
  // to 8), read 20 (head 8), write 20 -> tail 28 (60 writes total), count 20.
  task automatic test_wrap;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      #1;
      n_cmp++;
      if (wr_addr !== 5'((20 + i) % 32)) begin
        n_fail++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", i, wr_addr, (20 + i) % 32);
      end
      step(1'b1, 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    n_cmp++;
    if (rd_addr !== 5'd8 || data_count !== 6'd0) begin
      n_fail++; $display("FAIL wrap_head: got ra%0d c%0d want ra8 c0", rd_addr, data_count);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (wr_addr !== 5'd28 || data_count !== 6'd20) begin
      n_fail++; $display("FAIL wrap_tail: got wa%0d c%0d want wa28 c20", wr_addr, data_count);
    end
  endtask

  // Entry: head 8, tail 28, count 20.
  task automatic test_simul;
    logic       exp_we, exp_re, exp_wa, exp_ra, exp_ea, exp_ee;
    logic [4:0] exp_wp, exp_rp, exp_rp2, exp_wp2;
    logic [5:0] exp_c2;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    n_cmp++;
    if (data_count !== 6'd5 || rd_addr !== 5'd23) begin
      n_fail++; $display("FAIL simul_setup: got c%0d ra%0d want c5 ra23", data_count, rd_addr);
    end
`ifdef FIFO_OUT_SIMUL_RW_EN
    exp_we = 1'b1; exp_re = 1'b1; exp_wa = 1'b1; exp_ra = 1'b1;
    exp_wp = 5'd29; exp_rp = 5'd24;
    exp_rp2 = 5'd29; exp_wp2 = 5'd30; exp_c2 = 6'd1; exp_ea = 1'b1; exp_ee = 1'b1;
`else
    exp_we = 1'b0; exp_re = 1'b0; exp_wa = 1'b0; exp_ra = 1'b0;
    exp_wp = 5'd28; exp_rp = 5'd23;
    exp_rp2 = 5'd28; exp_wp2 = 5'd28; exp_c2 = 6'd0; exp_ea = 1'b0; exp_ee = 1'b0;
`endif
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    n_cmp++;
    if ({we, re} !== {exp_we, exp_re}) begin
      n_fail++; $display("FAIL simul_qual: got %b%b want %b%b", we, re, exp_we, exp_re);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if ({data_count, wr_addr, rd_addr} !== {6'd5, exp_wp, exp_rp}) begin
      n_fail++;
      $display("FAIL simul_ptrs: got c%0d wa%0d ra%0d want c5 wa%0d ra%0d",
               data_count, wr_addr, rd_addr, exp_wp, exp_rp);
    end
    n_cmp++;
    if ({wr_ack, rd_ack, wr_err, rd_err} !== {exp_wa, exp_ra, 2'b00}) begin
      n_fail++;
      $display("FAIL simul_flags: got %b want %b", {wr_ack, rd_ack, wr_err, rd_err},
               {exp_wa, exp_ra, 2'b00});
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    n_cmp++;
    if (empty !== 1'b1 || rd_addr !== exp_rp2) begin
      n_fail++; $display("FAIL simul_empty_setup: got e%b ra%0d want e1 ra%0d", empty, rd_addr, exp_rp2);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if ({data_count, wr_addr} !== {exp_c2, exp_wp2}) begin
      n_fail++;
      $display("FAIL simul_empty_ptrs: got c%0d wa%0d want c%0d wa%0d",
               data_count, wr_addr, exp_c2, exp_wp2);
    end
    n_cmp++;
    if ({wr_ack, rd_err, rd_ack, wr_err} !== {exp_ea, exp_ee, 2'b00}) begin
      n_fail++;
      $display("FAIL simul_empty_flags: got %b want %b", {wr_ack, rd_err, rd_ack, wr_err},
               {exp_ea, exp_ee, 2'b00});
    end
  endtask

  task automatic test_reset_mid;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (data_count !== 6'd17 || wr_ack !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got c%0d ack%b want c17 ack1", data_count, wr_ack);
    end
    wr_en = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({we, empty, full, data_count, wr_addr, rd_addr} !== {3'b010, 6'd0, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL mid_async: got we%b e%b f%b c%0d wa%0d ra%0d want we0 e1 f0 c0 wa0 ra0",
               we, empty, full, data_count, wr_addr, rd_addr);
    end
    n_cmp++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_async_flags: got %b want 0000", {wr_ack, wr_err, rd_ack, rd_err});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (wr_ack !== 1'b0 || data_count !== 6'd0) begin
      n_fail++; $display("FAIL mid_dropped: got ack%b c%0d want ack0 c0", wr_ack, data_count);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (we !== 1'b1 || wr_addr !== 5'd0) begin
      n_fail++; $display("FAIL mid_first_write: got we%b wa%0d want we1 wa0", we, wr_addr);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if ({wr_ack, data_count, wr_addr} !== {1'b1, 6'd1, 5'd1}) begin
      n_fail++;
      $display("FAIL mid_after: got ack%b c%0d wa%0d want ack1 c1 wa1", wr_ack, data_count, wr_addr);
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_wrap;
    test_simul;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
